// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_pkg                                                      |
// | Description : Scancodes, FSM state type and frame helpers for the PS/2     |
// |               keyboard transmitter.                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ps2_pkg;

    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_B     = 8'h32;
    localparam logic [7:0] SC_C     = 8'h21;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        GAP  = 2'd3
    } ps2_state_t;

    // Full 11-bit frame, bit 0 goes on the wire first: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

    // Key index 0 = Enter, 1 = B, 2 = C.
    function automatic logic [7:0] key_code(input logic [1:0] idx);
        logic [7:0] code;
        case (idx)
            2'd0:    code = SC_ENTER;
            2'd1:    code = SC_B;
            default: code = SC_C;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_byte_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_byte_fifo                                                |
// | Description : 8-entry x 8-bit synchronous FIFO with wrapping 3-bit         |
// |               pointers and an occupancy count.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ps2_byte_fifo (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty,
    output logic [3:0] count
);

    logic [7:0] r_mem [0:7];
    logic [2:0] r_wr_ptr;
    logic [2:0] r_rd_ptr;
    logic [3:0] r_count;
    logic       w_do_push;
    logic       w_do_pop;

    assign full      = r_count[3];
    assign empty     = (r_count == 4'd0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];

    // Blocked operations are dropped here, so the count always tracks the pointers.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= 3'd0;
            r_rd_ptr <= 3'd0;
            r_count  <= 4'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 3'd1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 3'd1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_keyboard_tx                                              |
// | Description : Device-side PS/2 keyboard transmitter: byte FIFO, frame FSM  |
// |               generating ps2clk/ps2data, optional Enter/B/C key encoder    |
// |               enabled by the PS2_KEYS_EN macro.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ps2_keyboard_tx
    import ps2_pkg::*;
#(
    parameter int CLK_MHZ    = 25,
    parameter int PS2_KHZ    = 10,
    parameter int GAP_HALVES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       key_enter,
    input  logic       key_b,
    input  logic       key_c,
    output logic       ps2clk,
    output logic       ps2data,
    output logic       busy
);

    localparam int c_half    = CLK_MHZ * 1000 / (2 * PS2_KHZ);
    localparam int c_gap     = GAP_HALVES * c_half;
    localparam int c_max     = (c_gap > c_half) ? c_gap : c_half;
    localparam int CW        = $clog2(c_max + 1);
    localparam logic [CW-1:0] c_half_last = CW'(c_half - 1);
    localparam logic [CW-1:0] c_gap_last  = CW'((c_gap > 0) ? c_gap - 1 : 0);

    ps2_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit_idx;
    logic [10:0]   r_shift;
    logic          r_ps2clk;
    logic          r_ps2data;

    logic          w_fifo_push;
    logic [7:0]    w_fifo_push_data;
    logic          w_fifo_pop;
    logic [7:0]    w_fifo_dout;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [3:0]    w_fifo_count;
    logic          w_enc_push;
    logic [7:0]    w_enc_data;
    logic          w_tx_fire;
    logic [10:0]   w_frame;

    assign tx_ready         = !w_fifo_full && !w_enc_push && !reset;
    assign w_tx_fire        = tx_valid && tx_ready;
    assign w_fifo_push      = w_enc_push || w_tx_fire;
    assign w_fifo_push_data = w_enc_push ? w_enc_data : tx_data;
    assign w_fifo_pop       = (r_state == IDLE) && !w_fifo_empty && !reset;
    assign w_frame          = ps2_frame(w_fifo_dout);

    assign ps2clk  = r_ps2clk;
    assign ps2data = r_ps2data;
    assign busy    = (r_state != IDLE) || !w_fifo_empty;

    ps2_byte_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_fifo_push),
        .push_data (w_fifo_push_data),
        .pop       (w_fifo_pop),
        .pop_data  (w_fifo_dout),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

`ifdef PS2_KEYS_EN
    // Bit order in every key vector: [0] Enter, [1] B, [2] C (also the service priority).
    logic [2:0] w_keys;
    logic [2:0] r_key_prev;
    logic [2:0] r_make_pend;
    logic [2:0] r_break_pend;
    logic [2:0] w_make_req;
    logic [2:0] w_break_req;
    logic [2:0] w_any_req;
    logic [2:0] w_sel_mask;
    logic [1:0] w_sel;
    logic       w_sel_valid;
    logic       w_serve_make;
    logic       w_serve_break;
    logic       r_brk_second;
    logic [1:0] r_brk_key;

    assign w_keys      = {key_c, key_b, key_enter};
    // Edges this cycle are served immediately, so tx_ready drops in the same cycle.
    assign w_make_req  = r_make_pend  | (w_keys & ~r_key_prev);
    assign w_break_req = r_break_pend | (~w_keys & r_key_prev);
    assign w_any_req   = w_make_req | w_break_req;
    assign w_sel_mask  = 3'b001 << w_sel;

    always_comb begin
        w_sel       = 2'd0;
        w_sel_valid = 1'b0;
        if (w_any_req[0]) begin
            w_sel       = 2'd0;
            w_sel_valid = 1'b1;
        end else if (w_any_req[1]) begin
            w_sel       = 2'd1;
            w_sel_valid = 1'b1;
        end else if (w_any_req[2]) begin
            w_sel       = 2'd2;
            w_sel_valid = 1'b1;
        end
    end

    always_comb begin
        w_enc_push    = 1'b0;
        w_enc_data    = SC_BREAK;
        w_serve_make  = 1'b0;
        w_serve_break = 1'b0;
        if (!reset) begin
            if (r_brk_second) begin
                // Space for this byte was reserved when the 0xF0 went in.
                w_enc_push = 1'b1;
                w_enc_data = key_code(r_brk_key);
            end else if (w_sel_valid) begin
                if ((w_make_req & w_sel_mask) != 3'd0) begin
                    if (!w_fifo_full) begin
                        w_enc_push   = 1'b1;
                        w_enc_data   = key_code(w_sel);
                        w_serve_make = 1'b1;
                    end
                end else if (w_fifo_count <= 4'd6) begin
                    w_enc_push    = 1'b1;
                    w_enc_data    = SC_BREAK;
                    w_serve_break = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_prev   <= 3'd0;
            r_make_pend  <= 3'd0;
            r_break_pend <= 3'd0;
            r_brk_second <= 1'b0;
            r_brk_key    <= 2'd0;
        end else begin
            r_key_prev   <= w_keys;
            r_make_pend  <= w_make_req  & ~(w_serve_make  ? w_sel_mask : 3'd0);
            r_break_pend <= w_break_req & ~(w_serve_break ? w_sel_mask : 3'd0);
            r_brk_second <= w_serve_break;
            if (w_serve_break) begin
                r_brk_key <= w_sel;
            end
        end
    end
`else
    logic w_unused_keys;

    assign w_enc_push    = 1'b0;
    assign w_enc_data    = 8'h00;
    assign w_unused_keys = ^{key_enter, key_b, key_c, w_fifo_count};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 4'd0;
            r_shift   <= '1;
            r_ps2clk  <= 1'b1;
            r_ps2data <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ps2clk  <= 1'b1;
                    r_ps2data <= 1'b1;
                    r_cnt     <= '0;
                    if (!w_fifo_empty) begin
                        r_shift   <= w_frame;
                        r_bit_idx <= 4'd0;
                        r_ps2data <= w_frame[0];
                        r_state   <= HIGH;
                    end
                end
                HIGH: begin
                    r_ps2data <= r_shift[0];
                    if (r_cnt == c_half_last) begin
                        r_cnt    <= '0;
                        r_ps2clk <= 1'b0;
                        r_state  <= LOW;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                LOW: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt     <= '0;
                        r_ps2clk  <= 1'b1;
                        r_shift   <= {1'b1, r_shift[10:1]};
                        r_bit_idx <= r_bit_idx + 4'd1;
                        if (r_bit_idx == 4'd10) begin
                            r_ps2data <= 1'b1;
                            r_state   <= (c_gap == 0) ? IDLE : GAP;
                        end else begin
                            // Next bit appears together with the rising clock.
                            r_ps2data <= r_shift[1];
                            r_state   <= HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                GAP: begin
                    r_ps2clk  <= 1'b1;
                    r_ps2data <= 1'b1;
                    if (r_cnt == c_gap_last) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ps2_keyboard_tx                                           |
// | Description : Scoreboard bench for ps2_keyboard_tx (H = 10 cycles); key    |
// |               encoder steps run when PS2_KEYS_EN is defined.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ps2_keyboard_tx;

    localparam int H = 10;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       key_enter;
    logic       key_b;
    logic       key_c;
    logic       ps2clk;
    logic       ps2data;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int mon_bit = 0;
    int mon_falls = 0;
    int mon_frames = 0;
    logic [10:0] exp_q[$];

    ps2_keyboard_tx #(
        .CLK_MHZ    (1),
        .PS2_KHZ    (50),
        .GAP_HALVES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .key_enter (key_enter),
        .key_b     (key_b),
        .key_c     (key_c),
        .ps2clk    (ps2clk),
        .ps2data   (ps2data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || mon_bit != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("quiet_in_budget", (n < budget), 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Frame monitor: samples the lines on the falling system clock edge.
    initial begin
        logic        pc;
        int          hl;
        int          ll;
        logic [10:0] fr;
        pc = 1'b1;
        hl = 0;
        ll = 0;
        fr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pc      = 1'b1;
                hl      = 0;
                ll      = 0;
                mon_bit = 0;
            end else begin
                if (pc && !ps2clk) begin
                    if (mon_bit > 0) check("high_phase_len", hl, H);
                    fr[mon_bit] = ps2data;
                    mon_bit++;
                    mon_falls++;
                    ll = 1;
                    if (mon_bit == 11) begin
                        mon_bit = 0;
                        mon_frames++;
                        check("frame_was_expected", (exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) check("frame_bits", fr, exp_q.pop_front());
                    end
                end else if (!pc && ps2clk) begin
                    check("low_phase_len", ll, H);
                    hl = 1;
                end else if (ps2clk) begin
                    hl++;
                end else begin
                    ll++;
                end
                pc = ps2clk;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc;
        int falls0;
        reset     = 1'b1;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        key_enter = 1'b0;
        key_b     = 1'b0;
        key_c     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ps2clk", ps2clk, 1);
        check("rst_ps2data", ps2data, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_ready", tx_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("idle_tx_ready", tx_ready, 1);

        // Single 0x5A: latency, bit pattern, busy length
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        exp_q.push_back(11'b110_1011_0100);
        @(negedge clk);
        tx_valid = 1'b0;
        check("pop_cycle_data", ps2data, 1);
        check("pop_cycle_busy", busy, 1);
        @(negedge clk);
        check("start_bit_data", ps2data, 0);
        check("start_bit_clk", ps2clk, 1);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("busy_len", n, 26 * H);
        wait_quiet(400);

        // Burst of 12 with no drain: 9 accepted
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            tx_data  = 8'hC0 + 8'(i);
            tx_valid = 1'b1;
            #1;
            check("burst_ready", tx_ready, (i < 9));
            if (tx_ready) begin
                exp_q.push_back(exp_frame(tx_data));
                acc++;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("burst_accepted", acc, 9);
        wait_quiet(9 * 300 + 100);

`ifdef PS2_KEYS_EN
        // key_b pulse: make, then break
        key_b = 1'b1;
        #1;
        check("keyb_rise_ready", tx_ready, 0);
        exp_q.push_back(exp_frame(8'h32));
        repeat (400) @(negedge clk);
        key_b = 1'b0;
        exp_q.push_back(exp_frame(8'hF0));
        exp_q.push_back(exp_frame(8'h32));
        wait_quiet(1000);

        // Enter rise collides with tx 0x11
        key_enter = 1'b1;
        tx_data   = 8'h11;
        tx_valid  = 1'b1;
        #1;
        check("enter_vs_tx_ready", tx_ready, 0);
        exp_q.push_back(exp_frame(8'h5A));
        @(negedge clk);
        #1;
        check("tx_after_enter_ready", tx_ready, 1);
        exp_q.push_back(exp_frame(8'h11));
        @(negedge clk);
        tx_valid = 1'b0;
        wait_quiet(800);
        key_enter = 1'b0;
        exp_q.push_back(exp_frame(8'hF0));
        exp_q.push_back(exp_frame(8'h5A));
        wait_quiet(800);

        // Enter and C together, then released together
        key_enter = 1'b1;
        key_c     = 1'b1;
        exp_q.push_back(exp_frame(8'h5A));
        exp_q.push_back(exp_frame(8'h21));
        wait_quiet(800);
        key_enter = 1'b0;
        key_c     = 1'b0;
        exp_q.push_back(exp_frame(8'hF0));
        exp_q.push_back(exp_frame(8'h5A));
        exp_q.push_back(exp_frame(8'hF0));
        exp_q.push_back(exp_frame(8'h21));
        wait_quiet(1400);
`endif

        // Reset during data bit 5 with a second byte queued
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h3C;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (mon_bit != 6 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reached_bit6", mon_bit, 6);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_ps2clk", ps2clk, 1);
        check("midrst_ps2data", ps2data, 1);
        check("midrst_busy", busy, 0);
        check("midrst_tx_ready", tx_ready, 0);
        reset  = 1'b0;
        falls0 = mon_falls;
        repeat (600) @(negedge clk);
        check("no_frames_after_rst", mon_falls, falls0);
        check("idle_after_rst_busy", busy, 0);
        check("idle_after_rst_data", ps2data, 1);
        check("queue_after_rst", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
